// File: rtl/spi_slave_rx.sv
// SPI responder for a CPOL=1/CPHA=1 master: oversamples sclk/cs_n/mosi in the clk domain,
// deserialises MOSI and serialises a buffered word onto MISO. Optional macro: SPI_SLAVE_ABORT_EN.
module spi_slave_rx #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sclk,
   input  logic             cs_n,
   input  logic             mosi,
   output logic             miso,
   output logic             miso_oe,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_load,
   output logic             tx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic [5:0]       bit_count,
   output logic             frame_abort
);

   localparam int unsigned CNT_W  = 6;
   localparam int unsigned PIPE_N = SYNC_STAGES + 1;

   typedef enum logic {
      ST_IDLE,
      ST_SHIFT
   } state_e;

   state_e state_q, state_d;

   // Synchroniser stages followed by the edge-detect register; bit order {sclk, cs_n, mosi}
   logic [2:0] pipe_q [PIPE_N];
   logic [2:0] pipe_d [PIPE_N];
   logic       sclk_prev_q;

   logic             sclk_s, cs_s, mosi_s;
   logic             rise_c, fall_c;

   logic             miso_q, miso_d;
   logic             miso_oe_q, miso_oe_d;
   logic             tx_ready_q, tx_ready_d;
   logic [WIDTH-1:0] tx_buf_q, tx_buf_d;
   logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic [WIDTH-1:0] rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic [CNT_W-1:0] bit_count_q, bit_count_d;
   logic             frame_abort_q, frame_abort_d;
   logic             consume_c;

   always_comb begin
      pipe_d[0] = {sclk, cs_n, mosi};
      for (int unsigned i = 1; i < PIPE_N; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   assign sclk_s = pipe_q[PIPE_N-1][2];
   assign cs_s   = pipe_q[PIPE_N-1][1];
   assign mosi_s = pipe_q[PIPE_N-1][0];
   assign rise_c = sclk_s & ~sclk_prev_q;
   assign fall_c = ~sclk_s & sclk_prev_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (!cs_s) state_d = ST_SHIFT;
         ST_SHIFT: if (cs_s)  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      miso_d        = miso_q;
      miso_oe_d     = miso_oe_q;
      tx_ready_d    = tx_ready_q;
      tx_buf_d      = tx_buf_q;
      tx_shift_d    = tx_shift_q;
      rx_shift_d    = rx_shift_q;
      rx_data_d     = rx_data_q;
      rx_valid_d    = 1'b0;
      bit_count_d   = bit_count_q;
      frame_abort_d = 1'b0;
      consume_c     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            miso_d      = 1'b0;
            miso_oe_d   = 1'b0;
            bit_count_d = '0;
            if (!cs_s) begin
               miso_oe_d = 1'b1;
               consume_c = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (cs_s) begin
               // Deselect wins over a coincident rise; the partial word is dropped
               miso_d      = 1'b0;
               miso_oe_d   = 1'b0;
               rx_shift_d  = '0;
               bit_count_d = '0;
`ifdef SPI_SLAVE_ABORT_EN
               frame_abort_d = (bit_count_q != '0);
`endif
            end else begin
               if (fall_c) begin
                  miso_d     = tx_shift_q[WIDTH-1];
                  tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
               end
               if (rise_c) begin
                  rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
                  if (bit_count_q == CNT_W'(WIDTH - 1)) begin
                     rx_data_d   = rx_shift_d;
                     rx_valid_d  = 1'b1;
                     bit_count_d = '0;
                     consume_c   = 1'b1;
                  end else begin
                     bit_count_d = bit_count_q + CNT_W'(1);
                  end
               end
            end
         end
         default: ;
      endcase

      // Consume sees the pre-load buffer state; a same-cycle load waits for the next boundary
      if (consume_c) begin
         tx_shift_d = tx_ready_q ? '0 : tx_buf_q;
         tx_ready_d = 1'b1;
      end
      if (tx_load && tx_ready_q) begin
         tx_buf_d   = tx_data;
         tx_ready_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < PIPE_N; i++) begin
            pipe_q[i] <= 3'b110;
         end
         sclk_prev_q   <= 1'b1;
         miso_q        <= 1'b0;
         miso_oe_q     <= 1'b0;
         tx_ready_q    <= 1'b1;
         tx_buf_q      <= '0;
         tx_shift_q    <= '0;
         rx_shift_q    <= '0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         bit_count_q   <= '0;
         frame_abort_q <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < PIPE_N; i++) begin
            pipe_q[i] <= pipe_d[i];
         end
         sclk_prev_q   <= sclk_s;
         miso_q        <= miso_d;
         miso_oe_q     <= miso_oe_d;
         tx_ready_q    <= tx_ready_d;
         tx_buf_q      <= tx_buf_d;
         tx_shift_q    <= tx_shift_d;
         rx_shift_q    <= rx_shift_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         bit_count_q   <= bit_count_d;
         frame_abort_q <= frame_abort_d;
      end
   end

   assign miso        = miso_q;
   assign miso_oe     = miso_oe_q;
   assign tx_ready    = tx_ready_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign bit_count   = bit_count_q;
   assign frame_abort = frame_abort_q;

endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

SPI responder for the CPOL=1/CPHA=1 link driven by the team's SPI master. It deserialises MOSI into WIDTH-bit words and serialises a locally supplied word onto MISO, MSB first. It runs in the system `clk` domain and oversamples `sclk`, `cs_n` and `mosi`. One instance sits behind each chip-select line (CS_SLAVE1, CS_SLAVE2).

## Interface

Parameters:
- WIDTH, 16, word length in bits (2..32)
- SYNC_STAGES, 2, synchroniser flops on `sclk`, `cs_n` and `mosi` (0..3). 0 is legal only when the master shares `clk`.

Ports:
- Clock and reset: reset synchronous, active-high; clock `clk`.
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- sclk  in  1  SPI clock, idles high
- cs_n  in  1  chip select, active low
- mosi  in  1  serial data from master
- miso  out  1  serial data to master
- miso_oe  out  1  MISO output enable, high while selected
- tx_data  in  WIDTH  word to transmit
- tx_load  in  1  write `tx_data` into the holding buffer
- tx_ready  out  1  holding buffer empty
- rx_data  out  WIDTH  last complete received word
- rx_valid  out  1  one-cycle pulse, `rx_data` updated
- bit_count  out  6  bits received in current word (0..WIDTH-1)
- frame_abort  out  1  one-cycle pulse, word truncated by `cs_n` (see Configuration)

## Operation

- Inputs pass through SYNC_STAGES flops, then one edge-detect register.
  - Rise = synchronised `sclk` is 1 and was 0 on the previous cycle.
  - Fall = synchronised `sclk` is 0 and was 1 on the previous cycle.
  - `mosi` takes the same delay as `sclk`.
- FSM:
  - IDLE
    - `miso_oe`=0, `miso`=0, `bit_count`=0.
    - On synchronised `cs_n`=0: load `tx_shift` from the buffer, or all-zero if `tx_ready`=1. Mark the buffer empty. Go to SHIFT.
  - SHIFT
    - On fall: `miso` <= `tx_shift[WIDTH-1]`, then `tx_shift` shifts left with a 0 fill.
    - On rise: `rx_shift` <= {`rx_shift[WIDTH-2:0]`, `mosi`}, and `bit_count` increments.
    - On the rise that completes bit WIDTH:
      - `rx_data` <= the full word and `rx_valid`=1 for one cycle.
      - `bit_count` <= 0.
      - `tx_shift` reloads from the buffer, or zeros if the buffer is empty. The buffer is marked empty.
      - Stays in SHIFT, so back-to-back words are allowed while selected.
    - Synchronised `cs_n`=1: go to IDLE, clear `rx_shift` and `bit_count`. If `bit_count`≠0, this is an abort.
- Before the first fall of a word, `miso` holds 0 with `miso_oe`=1.
- Holding buffer:
  - `tx_load` with `tx_ready`=1 writes the buffer and drives `tx_ready` to 0 the next cycle.
  - `tx_load` with `tx_ready`=0 is ignored. The buffer is not overwritten.
  - `tx_load` in the same cycle as a consume: the consume sees the old (empty) state and shifts zeros. The loaded word waits for the next word boundary.
- A rise and a `cs_n` deassert detected in the same cycle: `cs_n` wins and the bit is discarded.

## Timing

- Reset values:
  - `miso`=0, `miso_oe`=0, `tx_ready`=1.
  - `rx_data`=0, `rx_valid`=0, `bit_count`=0, `frame_abort`=0.
  - FSM=IDLE, buffer empty.
- Reset mid-frame abandons the word: no `rx_valid`, no `frame_abort`.
- `rx_valid` rises SYNC_STAGES+1 cycles after the `clk` edge that first samples the final `sclk` rise.
- `miso` changes SYNC_STAGES+1 cycles after the `clk` edge that first samples a `sclk` fall.
- `miso_oe` follows `cs_n` with the same SYNC_STAGES+1 latency.
- Minimum `sclk` half-period: 1 `clk` cycle when SYNC_STAGES=0, otherwise SYNC_STAGES+1 cycles.
- MISO is valid at the master's sampling rise only if the `sclk` low phase is ≥ SYNC_STAGES+2 cycles.

## Configuration

- `SPI_SLAVE_ABORT_EN` defined:
  - On abort, `frame_abort` pulses for one cycle, at the same latency as `rx_valid`.
  - `rx_data` is left unchanged.
  - A buffered tx word that was already consumed is lost.
- `SPI_SLAVE_ABORT_EN` undefined:
  - `frame_abort` is tied to 0.
  - The partial word is discarded silently.
  - Everything else is identical.

## Test plan

- Case 1, SYNC_STAGES=0, `sclk` toggling every `clk`:
  - Stimulus: master sends 16'hA5C3 under `cs_n`=0.
  - Response: `rx_data`=16'hA5C3, exactly one `rx_valid`, `bit_count` returns to 0.
- Case 2, full-duplex:
  - Stimulus: `tx_load` 16'h1234 before select; master sends 16'hFFFF.
  - Response: master samples 16'h1234 on MISO; `rx_data`=16'hFFFF; `tx_ready` goes 1→0→1 at select.
- Case 3, back-to-back words:
  - Stimulus: two words 16'h0001 and 16'h8000 with `cs_n` held low; buffer reloaded with 16'hBEEF between them.
  - Response: two `rx_valid` pulses; the second MISO word is 16'hBEEF.
- Case 4, underrun:
  - Stimulus: no `tx_load` before the frame.
  - Response: MISO carries 16'h0000; `tx_load` while `tx_ready`=0 does not alter the pending word.
- Case 5, abort:
  - Stimulus: `cs_n` deasserted after 7 bits.
  - With the macro: `frame_abort` pulses once, `rx_data` is unchanged, `miso_oe`=0.
  - Without the macro: `frame_abort` stays 0.
- Case 6, reset mid-frame:
  - Stimulus: `reset` asserted after 9 bits.
  - Response: all outputs return to their reset values; the next full frame 16'h5A5A is received correctly.
